microwave_timer: RTL



---
 rtl/microwave_pkg.sv | 15 +
 rtl/mmss_dec.sv | 39 +++
 rtl/microwave_timer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/microwave_pkg.sv
// Shared types for the microwave countdown timer: FSM states and the MM:SS BCD time word.
package microwave_pkg;

  typedef enum logic [1:0] {ENTRY, ARM, RUN, FIN} state_t;

  typedef struct packed {
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
  } mmss_t;

  localparam mmss_t MMSS_ZERO = '0;

endpackage

// File: rtl/mmss_dec.sv
// Combinational one-second decrement of an MM:SS BCD time, flagging a 00:00 result.
module mmss_dec
  import microwave_pkg::*;
(
  input  mmss_t cur,
  output mmss_t nxt,
  output logic  is_zero
);

  logic [6:0] secs;

  always_comb begin
    nxt  = cur;
    secs = '0;
    // Keypad may leave seconds above 59; treat those as a plain binary count.
    if (cur.s1 > 4'd5) begin
      secs   = 7'(cur.s1) * 7'd10 + 7'(cur.s0) - 7'd1;
      nxt.s1 = 4'(secs / 7'd10);
      nxt.s0 = 4'(secs % 7'd10);
    end else if (cur.s0 != 4'd0) begin
      nxt.s0 = cur.s0 - 4'd1;
    end else begin
      nxt.s0 = 4'd9;
      if (cur.s1 != 4'd0) begin
        nxt.s1 = cur.s1 - 4'd1;
      end else begin
        nxt.s1 = 4'd5;
        if (cur.m0 != 4'd0) begin
          nxt.m0 = cur.m0 - 4'd1;
        end else begin
          nxt.m0 = 4'd9;
          nxt.m1 = cur.m1 - 4'd1;
        end
      end
    end
    is_zero = (nxt == MMSS_ZERO);
  end

endmodule

// File: rtl/microwave_timer.sv
// Keypad entry and heat-gated MM:SS countdown feeding the cook controller's start/finish handshake.
// Optional quick-start at 00:00 is enabled by defining MICROWAVE_QUICK_START_EN.
module microwave_timer
  import microwave_pkg::*;
#(
  parameter int TICK_DIV  = 4,
  parameter int QUICK_SEC = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       key_start,
  input  logic       key_clear,
  input  logic       heat,
  output logic       start,
  output logic       finish,
  output logic       running,
  output logic [3:0] disp_m1,
  output logic [3:0] disp_m0,
  output logic [3:0] disp_s1,
  output logic [3:0] disp_s0
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  if (QUICK_SEC > 59) begin : g_quick_range
    $error("QUICK_SEC must not exceed 59");
  end

`ifdef MICROWAVE_QUICK_START_EN
  localparam mmss_t QUICK_TIME = '{m1: 4'd0, m0: 4'd0,
                                   s1: 4'(QUICK_SEC / 10), s0: 4'(QUICK_SEC % 10)};
`endif

  state_t        state, state_nxt;
  mmss_t         tm, tm_nxt, tm_dec;
  logic          dec_zero;
  logic [PW-1:0] pre, pre_nxt;

  mmss_dec u_dec (
    .cur     (tm),
    .nxt     (tm_dec),
    .is_zero (dec_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ENTRY;
      tm    <= MMSS_ZERO;
      pre   <= '0;
    end else begin
      state <= state_nxt;
      tm    <= tm_nxt;
      pre   <= pre_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tm_nxt    = tm;
    pre_nxt   = pre;
    case (state)
      ENTRY: begin
        if (key_clear) begin
          tm_nxt = MMSS_ZERO;
        end else if (key_start) begin
          if (tm != MMSS_ZERO) begin
            state_nxt = ARM;
          end
`ifdef MICROWAVE_QUICK_START_EN
          else begin
            tm_nxt    = QUICK_TIME;
            state_nxt = ARM;
          end
`endif
        end else if (key_valid && key_digit <= 4'd9) begin
          tm_nxt = '{m1: tm.m0, m0: tm.s1, s1: tm.s0, s0: key_digit};
        end
      end
      ARM: begin
        if (key_clear) begin
          state_nxt = ENTRY;
        end else if (heat) begin
          state_nxt = RUN;
          pre_nxt   = '0;
        end
      end
      RUN: begin
        // Door pause (heat low) freezes both prescaler and time.
        if (heat) begin
          if (pre == PRE_LAST) begin
            pre_nxt = '0;
            tm_nxt  = tm_dec;
            if (dec_zero) state_nxt = FIN;
          end else begin
            pre_nxt = pre + 1'b1;
          end
        end
      end
      FIN: begin
        if (!heat) begin
          state_nxt = ENTRY;
          tm_nxt    = MMSS_ZERO;
        end
      end
      default: state_nxt = ENTRY;
    endcase
  end

  assign start   = (state == ARM);
  assign finish  = (state == FIN);
  assign running = (state == RUN);
  assign disp_m1 = tm.m1;
  assign disp_m0 = tm.m0;
  assign disp_s1 = tm.s1;
  assign disp_s0 = tm.s0;

endmodule
